dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a valid/ready request
// interface. Each request is captured in IDLE and optionally held in WAIT
// for LATENCY cycles. It then completes in RESP with a one-cycle ready pulse,
// plus an err pulse if the address was out of range. Writes honour per-byte
// strobes. Read data is registered and held until the next read response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dmem_valid_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_err_o
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  // Byte-address limit in 33 bits so the compare can never wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  // Request fields captured at acceptance.
  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              in_range_q;

  // Registered response outputs.
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  // Storage; deliberately not reset.
  logic [31:0]       mem_q [DEPTH_WORDS];

  // Decode of the live request.
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic              accept_s;

  // Fields of the operation that completes on the edge entering RESP.
  logic              op_we_s;
  logic [IDX_W-1:0]  op_idx_s;
  logic [31:0]       op_wdata_s;
  logic [3:0]        op_wstrb_s;
  logic              op_in_range_s;
  logic              enter_resp_s;
  logic              mem_we_s;

  assign in_range_s = ({1'b0, dmem_addr_i} < ADDR_LIMIT);
  assign idx_s      = dmem_addr_i[IDX_W+1:2];
  assign accept_s   = (state_q == S_IDLE) && dmem_valid_i;

  // RESP always leaves to IDLE, so a next state of RESP means RESP is being entered.
  assign enter_resp_s = (state_d == S_RESP);

  // With LATENCY=0, RESP is entered on the accepting edge, before capture, so use live inputs.
  always_comb begin
    op_we_s       = we_q;
    op_idx_s      = idx_q;
    op_wdata_s    = wdata_q;
    op_wstrb_s    = wstrb_q;
    op_in_range_s = in_range_q;
    if (state_q == S_IDLE) begin
      op_we_s       = dmem_we_i;
      op_idx_s      = idx_s;
      op_wdata_s    = dmem_wdata_i;
      op_wstrb_s    = dmem_wstrb_i;
      op_in_range_s = in_range_s;
    end else begin
      op_we_s       = we_q;
      op_idx_s      = idx_q;
      op_wdata_s    = wdata_q;
      op_wstrb_s    = wstrb_q;
      op_in_range_s = in_range_q;
    end
  end

  assign mem_we_s = enter_resp_s && op_we_s && op_in_range_s;

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE accepts, WAIT counts down, RESP always returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_valid_i) begin
          cnt_d = LAT_LOAD;
          if (LAT_LOAD != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A count of 1 (or a stray 0) finishes the wait.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: ready/err pulse for the RESP cycle; read data loads only on read responses.
  always_comb begin
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (enter_resp_s) begin
      ready_d = 1'b1;
      err_d   = ~op_in_range_s;
      if (!op_we_s) begin
        if (op_in_range_s) begin
          rdata_d = mem_q[op_idx_s];
        end else begin
          rdata_d = 32'h0000_0000;
        end
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
    end
  end

  // Registered response outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Capture request fields at acceptance only; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
      in_range_q <= 1'b0;
    end else if (accept_s) begin
      we_q       <= dmem_we_i;
      idx_q      <= idx_s;
      wdata_q    <= dmem_wdata_i;
      wstrb_q    <= dmem_wstrb_i;
      in_range_q <= in_range_s;
    end else begin
      we_q       <= we_q;
      idx_q      <= idx_q;
      wdata_q    <= wdata_q;
      wstrb_q    <= wstrb_q;
      in_range_q <= in_range_q;
    end
  end

  // Commit strobed byte lanes of an in-range write on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (op_wstrb_s[b]) begin
          mem_q[op_idx_s][8*b +: 8] <= op_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign dmem_ready_o = ready_q;
  assign dmem_err_o   = err_q;
  assign dmem_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances are used:
// u_l1 (LATENCY=1, 1024 words), u_l0 (LATENCY=0, 16 words) and
// u_l3 (LATENCY=3, 1024 words). Each instance has its own reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  valid;
  logic [2:0]  we;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic [31:0] rdata [3];
  logic [2:0]  ready;
  logic [2:0]  err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .dmem_valid_i(valid[0]), .dmem_we_i(we[0]),
    .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_wstrb_i(wstrb[0]),
    .dmem_rdata_o(rdata[0]), .dmem_ready_o(ready[0]), .dmem_err_o(err[0]));

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_l0 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .dmem_valid_i(valid[1]), .dmem_we_i(we[1]),
    .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_wstrb_i(wstrb[1]),
    .dmem_rdata_o(rdata[1]), .dmem_ready_o(ready[1]), .dmem_err_o(err[1]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_n_i(rst_n[2]), .dmem_valid_i(valid[2]), .dmem_we_i(we[2]),
    .dmem_addr_i(addr[2]), .dmem_wdata_i(wdata[2]), .dmem_wstrb_i(wstrb[2]),
    .dmem_rdata_o(rdata[2]), .dmem_ready_o(ready[2]), .dmem_err_o(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at posedge+1, check ready stays low for lat cycles,
  // then check the response, the one-cycle pulse width and the return to idle.
  // With corrupt=1 the request inputs are scrambled right after acceptance.
  task automatic req(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int lat,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic corrupt, input string tag);
    valid[k] = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    @(posedge clk); #1;
    if (corrupt) begin
      addr[k]  = 32'h0000_0010;
      wdata[k] = 32'h0000_0000;
      wstrb[k] = 4'hF;
      we[k]    = ~w;
    end
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_wait_ready"}, {31'd0, ready[k]}, 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_ready"}, {31'd0, ready[k]}, 32'd1);
    chk({tag, "_err"},   {31'd0, err[k]},   {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata[k], exp_rd);
    valid[k] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, {30'd0, err[k], ready[k]}, 32'd0);
  endtask

  initial begin
    rst_n = 3'b000;
    valid = 3'b000;
    we    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k]  = 32'h0;
      wdata[k] = 32'h0;
      wstrb[k] = 4'h0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_ready", k), {31'd0, ready[k]}, 32'd0);
      chk($sformatf("rst%0d_err", k),   {31'd0, err[k]},   32'd0);
      chk($sformatf("rst%0d_rdata", k), rdata[k], 32'h0);
    end
    rst_n = 3'b111;

    // LATENCY=1, 1024 words
    req(0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 1, 32'h0,        1'b0, 1'b0, "l1_w10");
    req(0, 1'b0, 32'h10,       32'h0,        4'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0, "l1_r10");
    req(0, 1'b1, 32'h20,       32'h11223344, 4'hF, 1, 32'hDEADBEEF, 1'b0, 1'b0, "l1_w20_pre");
    req(0, 1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 1, 32'hDEADBEEF, 1'b0, 1'b0, "l1_w20_part");
    req(0, 1'b0, 32'h20,       32'h0,        4'h0, 1, 32'h11BB33DD, 1'b0, 1'b0, "l1_r20_part");
    req(0, 1'b1, 32'h0,        32'h12345678, 4'hF, 1, 32'h11BB33DD, 1'b0, 1'b0, "l1_w0");
    req(0, 1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 1, 32'h11BB33DD, 1'b1, 1'b0, "l1_w1000_oor");
    req(0, 1'b0, 32'h1000,     32'h0,        4'h0, 1, 32'h0,        1'b1, 1'b0, "l1_r1000_oor");
    req(0, 1'b0, 32'h0,        32'h0,        4'h0, 1, 32'h12345678, 1'b0, 1'b0, "l1_r0_intact");
    req(0, 1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 1, 32'h12345678, 1'b0, 1'b0, "l1_wlast");
    req(0, 1'b0, 32'hFFF,      32'h0,        4'h0, 1, 32'hCAFEF00D, 1'b0, 1'b0, "l1_rlast_lowbits");
    req(0, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 1, 32'h0,        1'b1, 1'b0, "l1_rtop_nowrap");
    req(0, 1'b1, 32'h10,       32'h0,        4'h0, 1, 32'h0,        1'b0, 1'b0, "l1_w10_nostrb");
    req(0, 1'b0, 32'h10,       32'h0,        4'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0, "l1_r10_nostrb");
    req(0, 1'b1, 32'h30,       32'h55AA55AA, 4'hF, 1, 32'hDEADBEEF, 1'b0, 1'b1, "l1_w30_scramble");
    req(0, 1'b0, 32'h30,       32'h0,        4'h0, 1, 32'h55AA55AA, 1'b0, 1'b0, "l1_r30");
    req(0, 1'b0, 32'h10,       32'h0,        4'h0, 1, 32'hDEADBEEF, 1'b0, 1'b0, "l1_r10_untouched");

    // LATENCY=0, 16 words (byte limit 0x40)
    req(1, 1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0, 1'b0, "l0_w3c");
    req(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, 1'b0, "l0_w40_oor");
    req(1, 1'b1, 32'h04, 32'h01020304, 4'hF, 0, 32'h0, 1'b0, 1'b0, "l0_w04");
    req(1, 1'b1, 32'h08, 32'h0A0B0C0D, 4'hF, 0, 32'h0, 1'b0, 1'b0, "l0_w08");
    // Valid held high over three reads: a ready pulse every second cycle.
    valid[1] = 1'b1;
    we[1]    = 1'b0;
    addr[1]  = 32'h04;
    @(posedge clk); #1;
    chk("b2b_1_ready", {31'd0, ready[1]}, 32'd1);
    chk("b2b_1_rdata", rdata[1], 32'h01020304);
    addr[1] = 32'h08;
    @(posedge clk); #1;
    chk("b2b_1_gap", {31'd0, ready[1]}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_2_ready", {31'd0, ready[1]}, 32'd1);
    chk("b2b_2_rdata", rdata[1], 32'h0A0B0C0D);
    addr[1] = 32'h3C;
    @(posedge clk); #1;
    chk("b2b_2_gap", {31'd0, ready[1]}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_3_ready", {31'd0, ready[1]}, 32'd1);
    chk("b2b_3_rdata", rdata[1], 32'hA5A5A5A5);
    chk("b2b_3_err",   {31'd0, err[1]},   32'd0);
    valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_3_gap", {31'd0, ready[1]}, 32'd0);
    req(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h0, 1'b1, 1'b0, "l0_r40_oor");

    // LATENCY=3: reset during the second WAIT cycle aborts a write
    req(2, 1'b1, 32'h40, 32'h0,        4'hF, 3, 32'h0,        1'b0, 1'b0, "l3_w40_zero");
    req(2, 1'b1, 32'h44, 32'h13579BDF, 4'hF, 3, 32'h0,        1'b0, 1'b0, "l3_w44");
    req(2, 1'b0, 32'h44, 32'h0,        4'h0, 3, 32'h13579BDF, 1'b0, 1'b0, "l3_r44");
    valid[2] = 1'b1;
    we[2]    = 1'b1;
    addr[2]  = 32'h40;
    wdata[2] = 32'h87654321;
    wstrb[2] = 4'hF;
    @(posedge clk); #1;
    chk("abort_wait1_ready", {31'd0, ready[2]}, 32'd0);
    @(posedge clk); #1;
    chk("abort_wait2_ready", {31'd0, ready[2]}, 32'd0);
    rst_n[2] = 1'b0;
    valid[2] = 1'b0;
    #1;
    chk("abort_rst_ready", {31'd0, ready[2]}, 32'd0);
    chk("abort_rst_err",   {31'd0, err[2]},   32'd0);
    chk("abort_rst_rdata", rdata[2], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_hold_ready", {31'd0, ready[2]}, 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    req(2, 1'b0, 32'h40, 32'h0, 4'h0, 3, 32'h0,        1'b0, 1'b0, "l3_r40_after_abort");
    req(2, 1'b0, 32'h44, 32'h0, 4'h0, 3, 32'h13579BDF, 1'b0, 1'b0, "l3_r44_kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
